// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB retire stage: load funct3 codes, FSM state
// encoding and a small state-decode helper.
package mem_wb_stage_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      WB_IDLE      = 2'b00,
      WB_WAIT_LOAD = 2'b01,
      WB_COMMIT    = 2'b10,
      WB_DRAIN     = 2'b11
   } wb_state_e;

   // The stage takes a new instruction only while idle or retiring the previous one.
   function automatic logic state_can_accept(input wb_state_e s);
      return (s == WB_IDLE) || (s == WB_COMMIT);
   endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load data alignment: selects the byte/half addressed by addr_i
// from the raw word, extends it per funct3 and flags misaligned accesses.
module mem_wb_stage_load_align
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] wdata_o,
   output logic            misalign_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select for sub-word loads.
   always_comb begin
      byte_s = rdata_i[{addr_i, 3'b000} +: 8];
      half_s = rdata_i[{addr_i[1], 4'b0000} +: 16];
   end

   // Extension and alignment check; unknown funct3 behaves as a word load.
   always_comb begin
      wdata_o    = rdata_i;
      misalign_o = 1'b0;
      case (funct3_i)
         F3_LB: begin
            wdata_o    = {{(XLEN-8){byte_s[7]}}, byte_s};
            misalign_o = 1'b0;
         end
         F3_LBU: begin
            wdata_o    = {{(XLEN-8){1'b0}}, byte_s};
            misalign_o = 1'b0;
         end
         F3_LH: begin
            wdata_o    = {{(XLEN-16){half_s[15]}}, half_s};
            misalign_o = addr_i[0];
         end
         F3_LHU: begin
            wdata_o    = {{(XLEN-16){1'b0}}, half_s};
            misalign_o = addr_i[0];
         end
         default: begin
            wdata_o    = rdata_i;
            misalign_o = (addr_i != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB retire stage: single-entry buffer, load-response wait with timeout, flush
// draining and registered regfile write / commit outputs.
// Optional macro WB_COMMIT_TRACE_EN adds a commit trace report on every commit.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int REG_AW       = 5,
   parameter int LOAD_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              I_valid,
   output logic              O_ready,
   input  logic [XLEN-1:0]   I_pc,
   input  logic [XLEN-1:0]   I_inst,
   input  logic              I_rd_we,
   input  logic [REG_AW-1:0] I_rd_waddr,
   input  logic [XLEN-1:0]   I_result,
   input  logic              I_is_load,
   input  logic [2:0]        I_funct3,
   input  logic              I_mem_rvalid,
   input  logic [XLEN-1:0]   I_mem_rdata,
   input  logic              I_flush,
   output logic              O_rd_we,
   output logic [REG_AW-1:0] O_rd_waddr,
   output logic [XLEN-1:0]   O_rd_wdata,
   output logic              O_commit,
   output logic [XLEN-1:0]   O_commit_pc,
   output logic [XLEN-1:0]   O_commit_inst,
   output logic              O_exc_misalign,
   output logic              O_exc_timeout
);

   localparam int                CNT_W     = $clog2(LOAD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(LOAD_TIMEOUT);
   localparam logic [REG_AW-1:0] ZERO_REG  = {REG_AW{1'b0}};
   localparam logic [XLEN-1:0]   ZERO_WORD = {XLEN{1'b0}};

   wb_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   inst_q, inst_d;
   logic              rd_we_q, rd_we_d;
   logic [REG_AW-1:0] waddr_q, waddr_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;

   logic              commit_q, commit_d;
   logic              out_we_q, out_we_d;
   logic [REG_AW-1:0] out_waddr_q, out_waddr_d;
   logic [XLEN-1:0]   out_wdata_q, out_wdata_d;
   logic [XLEN-1:0]   out_pc_q, out_pc_d;
   logic [XLEN-1:0]   out_inst_q, out_inst_d;
   logic              exc_mis_q, exc_mis_d;
   logic              exc_to_q, exc_to_d;

   logic              ready_s;
   logic              accept_s;
   logic              mis_acc_s;
   logic              timeout_s;
   logic [2:0]        al_f3_s;
   logic [1:0]        al_off_s;
   logic [XLEN-1:0]   al_wdata_s;
   logic              al_mis_s;

   // The aligner checks the incoming instruction at accept and formats the response while waiting.
   always_comb begin
      if (state_q == WB_WAIT_LOAD) begin
         al_f3_s  = f3_q;
         al_off_s = off_q;
      end else begin
         al_f3_s  = I_funct3;
         al_off_s = I_result[1:0];
      end
   end

   mem_wb_stage_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .funct3_i   (al_f3_s),
      .addr_i     (al_off_s),
      .rdata_i    (I_mem_rdata),
      .wdata_o    (al_wdata_s),
      .misalign_o (al_mis_s)
   );

   assign ready_s   = state_can_accept(state_q);
   assign accept_s  = I_valid && ready_s && !I_flush;
   assign mis_acc_s = I_is_load && al_mis_s;
   assign timeout_s = (cnt_q == CNT_MAX);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= WB_IDLE;
         cnt_q       <= CNT_ZERO;
         pc_q        <= ZERO_WORD;
         inst_q      <= ZERO_WORD;
         rd_we_q     <= 1'b0;
         waddr_q     <= ZERO_REG;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         commit_q    <= 1'b0;
         out_we_q    <= 1'b0;
         out_waddr_q <= ZERO_REG;
         out_wdata_q <= ZERO_WORD;
         out_pc_q    <= ZERO_WORD;
         out_inst_q  <= ZERO_WORD;
         exc_mis_q   <= 1'b0;
         exc_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         rd_we_q     <= rd_we_d;
         waddr_q     <= waddr_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         commit_q    <= commit_d;
         out_we_q    <= out_we_d;
         out_waddr_q <= out_waddr_d;
         out_wdata_q <= out_wdata_d;
         out_pc_q    <= out_pc_d;
         out_inst_q  <= out_inst_d;
         exc_mis_q   <= exc_mis_d;
         exc_to_q    <= exc_to_d;
      end
   end

   // Next-state logic; a flush that coincides with the response consumes it directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE, WB_COMMIT: begin
            if (accept_s) begin
               if (I_is_load && !al_mis_s) begin
                  state_d = WB_WAIT_LOAD;
               end else begin
                  state_d = WB_COMMIT;
               end
            end else begin
               state_d = WB_IDLE;
            end
         end
         WB_WAIT_LOAD: begin
            if (I_flush) begin
               state_d = I_mem_rvalid ? WB_IDLE : WB_DRAIN;
            end else if (I_mem_rvalid || timeout_s) begin
               state_d = WB_COMMIT;
            end else begin
               state_d = WB_WAIT_LOAD;
            end
         end
         WB_DRAIN: begin
            if (I_mem_rvalid || timeout_s) begin
               state_d = WB_IDLE;
            end else begin
               state_d = WB_DRAIN;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // Buffer, timeout counter and next commit-output values; outputs are zero outside COMMIT.
   always_comb begin
      pc_d        = pc_q;
      inst_d      = inst_q;
      rd_we_d     = rd_we_q;
      waddr_d     = waddr_q;
      f3_d        = f3_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      commit_d    = 1'b0;
      out_we_d    = 1'b0;
      out_waddr_d = ZERO_REG;
      out_wdata_d = ZERO_WORD;
      out_pc_d    = ZERO_WORD;
      out_inst_d  = ZERO_WORD;
      exc_mis_d   = 1'b0;
      exc_to_d    = 1'b0;
      case (state_q)
         WB_IDLE, WB_COMMIT: begin
            if (accept_s) begin
               pc_d    = I_pc;
               inst_d  = I_inst;
               rd_we_d = I_rd_we;
               waddr_d = I_rd_waddr;
               f3_d    = I_funct3;
               off_d   = I_result[1:0];
               cnt_d   = CNT_ZERO;
               if (!I_is_load || mis_acc_s) begin
                  commit_d    = 1'b1;
                  out_we_d    = I_rd_we && (I_rd_waddr != ZERO_REG) && !mis_acc_s;
                  out_waddr_d = I_rd_waddr;
                  out_wdata_d = I_result;
                  out_pc_d    = I_pc;
                  out_inst_d  = I_inst;
                  exc_mis_d   = mis_acc_s;
               end else begin
                  commit_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         WB_WAIT_LOAD: begin
            if (I_flush) begin
               cnt_d = CNT_ZERO;
            end else if (I_mem_rvalid) begin
               commit_d    = 1'b1;
               out_we_d    = rd_we_q && (waddr_q != ZERO_REG);
               out_waddr_d = waddr_q;
               out_wdata_d = al_wdata_s;
               out_pc_d    = pc_q;
               out_inst_d  = inst_q;
            end else if (timeout_s) begin
               commit_d    = 1'b1;
               out_waddr_d = waddr_q;
               out_pc_d    = pc_q;
               out_inst_d  = inst_q;
               exc_to_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WB_DRAIN: begin
            if (I_mem_rvalid || timeout_s) begin
               cnt_d = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: cnt_d = CNT_ZERO;
      endcase
   end

   assign O_ready        = ready_s;
   assign O_commit       = commit_q;
   assign O_rd_we        = out_we_q;
   assign O_rd_waddr     = out_waddr_q;
   assign O_rd_wdata     = out_wdata_q;
   assign O_commit_pc    = out_pc_q;
   assign O_commit_inst  = out_inst_q;
   assign O_exc_misalign = exc_mis_q;
   assign O_exc_timeout  = exc_to_q;

`ifdef WB_COMMIT_TRACE_EN
   // Report every retiring instruction to the difftest harness.
   always_ff @(posedge clk) begin
      if (commit_q) begin
         $display("commit_trace pc=%h inst=%h rd_we=%b waddr=%0d wdata=%h",
                  out_pc_q, out_inst_q, out_we_q, out_waddr_q, out_wdata_q);
      end
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: retire latency, load alignment,
// misalign/timeout exceptions, flush draining, back-to-back commits and reset.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        I_valid;
   logic        O_ready;
   logic [31:0] I_pc;
   logic [31:0] I_inst;
   logic        I_rd_we;
   logic [4:0]  I_rd_waddr;
   logic [31:0] I_result;
   logic        I_is_load;
   logic [2:0]  I_funct3;
   logic        I_mem_rvalid;
   logic [31:0] I_mem_rdata;
   logic        I_flush;
   logic        O_rd_we;
   logic [4:0]  O_rd_waddr;
   logic [31:0] O_rd_wdata;
   logic        O_commit;
   logic [31:0] O_commit_pc;
   logic [31:0] O_commit_inst;
   logic        O_exc_misalign;
   logic        O_exc_timeout;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .I_valid        (I_valid),
      .O_ready        (O_ready),
      .I_pc           (I_pc),
      .I_inst         (I_inst),
      .I_rd_we        (I_rd_we),
      .I_rd_waddr     (I_rd_waddr),
      .I_result       (I_result),
      .I_is_load      (I_is_load),
      .I_funct3       (I_funct3),
      .I_mem_rvalid   (I_mem_rvalid),
      .I_mem_rdata    (I_mem_rdata),
      .I_flush        (I_flush),
      .O_rd_we        (O_rd_we),
      .O_rd_waddr     (O_rd_waddr),
      .O_rd_wdata     (O_rd_wdata),
      .O_commit       (O_commit),
      .O_commit_pc    (O_commit_pc),
      .O_commit_inst  (O_commit_inst),
      .O_exc_misalign (O_exc_misalign),
      .O_exc_timeout  (O_exc_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // {ready, commit, rd_we, exc_misalign, exc_timeout}
   function automatic logic [4:0] ctl();
      return {O_ready, O_commit, O_rd_we, O_exc_misalign, O_exc_timeout};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [31:0] pc, input logic load, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] res);
      I_valid    = 1'b1;
      I_pc       = pc;
      I_inst     = pc + 32'h0000_0033;
      I_rd_we    = 1'b1;
      I_rd_waddr = rd;
      I_result   = res;
      I_is_load  = load;
      I_funct3   = f3;
   endtask

   task automatic clr_valid();
      I_valid   = 1'b0;
      I_is_load = 1'b0;
   endtask

   // Accept a load (with a stray response in the accept cycle), respond lat cycles later.
   task automatic load_op(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] rdata,
                          input int lat, input logic [31:0] exp);
      drive_op(pc, 1'b1, f3, rd, addr);
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = 32'h1111_1111;
      chk({tag, "_rdy"}, {31'd0, O_ready}, 32'd1);
      tick();
      clr_valid();
      I_mem_rvalid = 1'b0;
      chk({tag, "_wait"}, {27'd0, ctl()}, 32'd0);
      for (int i = 1; i < lat; i++) tick();
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = rdata;
      tick();
      I_mem_rvalid = 1'b0;
      chk({tag, "_ctl"}, {27'd0, ctl()}, {27'd0, 1'b1, 1'b1, (rd != 5'd0), 2'b00});
      chk({tag, "_pc"}, O_commit_pc, pc);
      if (rd != 5'd0) chk({tag, "_wdata"}, O_rd_wdata, exp);
      tick();
      chk({tag, "_end"}, {27'd0, ctl()}, 32'h10);
   endtask

   task automatic misalign_op(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                              input logic [31:0] addr);
      drive_op(pc, 1'b1, f3, 5'd9, addr);
      tick();
      clr_valid();
      chk({tag, "_ctl"}, {27'd0, ctl()}, 32'h1A);
      chk({tag, "_pc"}, O_commit_pc, pc);
      tick();
      chk({tag, "_end"}, {27'd0, ctl()}, 32'h10);
   endtask

   initial begin
      logic early;
      rst_n        = 1'b0;
      I_valid      = 1'b0;
      I_pc         = 32'd0;
      I_inst       = 32'd0;
      I_rd_we      = 1'b0;
      I_rd_waddr   = 5'd0;
      I_result     = 32'd0;
      I_is_load    = 1'b0;
      I_funct3     = 3'd0;
      I_mem_rvalid = 1'b0;
      I_mem_rdata  = 32'd0;
      I_flush      = 1'b0;

      repeat (2) tick();
      chk("rst_ctl", {27'd0, ctl()}, 32'h10);
      chk("rst_waddr", {27'd0, O_rd_waddr}, 32'd0);
      chk("rst_wdata", O_rd_wdata, 32'd0);
      chk("rst_pc", O_commit_pc, 32'd0);
      chk("rst_inst", O_commit_inst, 32'd0);
      rst_n = 1'b1;

      // ADD x5 = 0x1234, visible the next cycle
      drive_op(32'h100, 1'b0, 3'd0, 5'd5, 32'h1234);
      chk("add_rdy", {31'd0, O_ready}, 32'd1);
      tick();
      clr_valid();
      chk("add_ctl", {27'd0, ctl()}, 32'h1C);
      chk("add_waddr", {27'd0, O_rd_waddr}, 32'd5);
      chk("add_wdata", O_rd_wdata, 32'h1234);
      chk("add_pc", O_commit_pc, 32'h100);
      chk("add_inst", O_commit_inst, 32'h133);
      tick();
      chk("add_end", {27'd0, ctl()}, 32'h10);

      // Load alignment / extension
      load_op("lb3",   32'h104, 3'b000, 5'd6,  32'h1003, 32'h80FF_0000, 3, 32'hFFFF_FF80);
      load_op("lhu2",  32'h108, 3'b101, 5'd9,  32'h1002, 32'h8001_7FFE, 1, 32'h0000_8001);
      load_op("lh2",   32'h10C, 3'b001, 5'd10, 32'h1002, 32'h8001_7FFE, 2, 32'hFFFF_8001);
      load_op("lh0",   32'h110, 3'b001, 5'd10, 32'h1000, 32'h8001_7FFE, 1, 32'h0000_7FFE);
      load_op("lbu1",  32'h114, 3'b100, 5'd11, 32'h1001, 32'h0000_A500, 1, 32'h0000_00A5);
      load_op("lb0",   32'h118, 3'b000, 5'd11, 32'h1000, 32'h0000_A57F, 1, 32'h0000_007F);
      load_op("lb2",   32'h11C, 3'b000, 5'd11, 32'h1002, 32'h00C3_0000, 2, 32'hFFFF_FFC3);
      load_op("lw0",   32'h120, 3'b010, 5'd12, 32'h1000, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
      load_op("unk0",  32'h124, 3'b111, 5'd13, 32'h1000, 32'h1234_5678, 1, 32'h1234_5678);
      load_op("lw_x0", 32'h128, 3'b010, 5'd0,  32'h1000, 32'h5555_AAAA, 1, 32'h0);

      // Misaligned loads skip the wait entirely
      misalign_op("mis_lw2",  32'h130, 3'b010, 32'h2002);
      misalign_op("mis_lhu3", 32'h134, 3'b101, 32'h2003);
      misalign_op("mis_unk1", 32'h138, 3'b111, 32'h2001);

      // LH offset 1, then an ADD accepted during that COMMIT cycle
      drive_op(32'h200, 1'b1, 3'b001, 5'd7, 32'h2001);
      tick();
      chk("lh1_ctl", {27'd0, ctl()}, 32'h1A);
      drive_op(32'h204, 1'b0, 3'd0, 5'd8, 32'hBEEF);
      tick();
      clr_valid();
      chk("lh1_add_ctl", {27'd0, ctl()}, 32'h1C);
      chk("lh1_add_waddr", {27'd0, O_rd_waddr}, 32'd8);
      chk("lh1_add_wdata", O_rd_wdata, 32'hBEEF);
      chk("lh1_add_pc", O_commit_pc, 32'h204);
      tick();
      chk("lh1_end", {27'd0, ctl()}, 32'h10);

      // Flush in WAIT_LOAD: response discarded, ready the cycle after it
      drive_op(32'h300, 1'b1, 3'b010, 5'd14, 32'h3000);
      tick();
      clr_valid();
      I_flush = 1'b1;
      chk("fl_wait", {27'd0, ctl()}, 32'd0);
      tick();
      I_flush = 1'b0;
      chk("fl_drain", {27'd0, ctl()}, 32'd0);
      tick();
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = 32'hCAFE_F00D;
      chk("fl_drain2", {27'd0, ctl()}, 32'd0);
      tick();
      I_mem_rvalid = 1'b0;
      chk("fl_after", {27'd0, ctl()}, 32'h10);

      // Flush in IDLE blocks the accept
      drive_op(32'h400, 1'b0, 3'd0, 5'd3, 32'h55);
      I_flush = 1'b1;
      tick();
      clr_valid();
      I_flush = 1'b0;
      chk("fl_idle", {27'd0, ctl()}, 32'h10);

      // Flush in COMMIT: commit completes, new op blocked
      drive_op(32'h404, 1'b0, 3'd0, 5'd3, 32'h66);
      tick();
      chk("fl_cmt_ctl", {27'd0, ctl()}, 32'h1C);
      drive_op(32'h408, 1'b0, 3'd0, 5'd4, 32'h77);
      I_flush = 1'b1;
      tick();
      clr_valid();
      I_flush = 1'b0;
      chk("fl_cmt_next", {27'd0, ctl()}, 32'h10);

      // Write to x0 commits without a regfile write
      drive_op(32'h500, 1'b0, 3'd0, 5'd0, 32'h99);
      tick();
      clr_valid();
      chk("x0_ctl", {27'd0, ctl()}, 32'h18);
      tick();

      // Load timeout: 256 waiting cycles, then a suppressed commit with exc_timeout
      drive_op(32'h600, 1'b1, 3'b010, 5'd15, 32'h6000);
      tick();
      clr_valid();
      early = 1'b0;
      for (int k = 0; k < 256; k++) begin
         early = early | O_commit | O_ready | O_exc_timeout;
         tick();
      end
      chk("to_early", {31'd0, early}, 32'd0);
      chk("to_ctl", {27'd0, ctl()}, 32'h19);
      chk("to_pc", O_commit_pc, 32'h600);
      tick();
      chk("to_end", {27'd0, ctl()}, 32'h10);

      // Five back-to-back non-loads
      for (int k = 0; k < 5; k++) begin
         drive_op(32'h700 + 32'(k * 4), 1'b0, 3'd0, 5'(16 + k), 32'hA0 + 32'(k));
         tick();
         chk("b2b_ctl", {27'd0, ctl()}, 32'h1C);
         chk("b2b_waddr", {27'd0, O_rd_waddr}, 32'(16 + k));
         chk("b2b_wdata", O_rd_wdata, 32'hA0 + 32'(k));
      end
      clr_valid();
      tick();
      chk("b2b_end", {27'd0, ctl()}, 32'h10);

      // Reset during COMMIT and during WAIT_LOAD
      drive_op(32'h800, 1'b0, 3'd0, 5'd20, 32'hAA);
      tick();
      clr_valid();
      chk("rc_pre", {27'd0, ctl()}, 32'h1C);
      rst_n = 1'b0;
      #1;
      chk("rc_ctl", {27'd0, ctl()}, 32'h10);
      chk("rc_wdata", O_rd_wdata, 32'd0);
      rst_n = 1'b1;
      drive_op(32'h804, 1'b1, 3'b010, 5'd21, 32'h8000);
      tick();
      clr_valid();
      chk("rw_pre", {27'd0, ctl()}, 32'd0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rw_ctl", {27'd0, ctl()}, 32'h10);
      chk("rw_waddr", {27'd0, O_rd_waddr}, 32'd0);
      chk("rw_pc", O_commit_pc, 32'd0);
      rst_n = 1'b1;
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = 32'h7777_7777;
      tick();
      I_mem_rvalid = 1'b0;
      chk("rw_lost", {27'd0, ctl()}, 32'h10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
